avr_prefetch: RTL and testbench
===============================

AVR_PREFETCH -- requirements
Module: avr_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter NOP_WORD, default 16'h0000, word presented when no valid instruction.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  CPU holds current instruction; no pop.
REQ-006 pc_src  input  3  CPU PC control: 000 reset-to-0, 001 hold, 010 next, 011 skip (PC+2), 100 relative, 101 absolute, 11x treated as 001.
REQ-007 jmp  input  16  relative offset (100) or absolute target (101).
REQ-008 pm_req  output  1  program-memory read request.
REQ-009 pm_addr  output  16  word address of request.
REQ-010 pm_ack  input  1  read done, pm_data valid this cycle; may be asserted in the same cycle as pm_req.
REQ-011 pm_data  input  16  instruction word.
REQ-012 cur_instr  output  16  head-of-queue instruction, else NOP_WORD.
REQ-013 current_pc  output  16  word address of cur_instr.
REQ-014 instr_valid  output  1  cur_instr is a real fetched word.

Function
REQ-015 SHALL hold a fetch pointer fpc (16 bit), a DEPTH-entry FIFO of {pc, instr}, a count (0..DEPTH), an outstanding flag and a discard flag.
REQ-016 pm_req SHALL be 1 when count + outstanding < DEPTH, or while a request is outstanding; pm_addr = fpc.
REQ-017 Once pm_req rises, pm_addr SHALL stay stable and pm_req high until the cycle pm_ack = 1, even across a redirect; at most one request is outstanding.
REQ-018 On pm_ack with discard = 0 and no redirect that cycle: push {fpc, pm_data}; fpc <= fpc + 1 (mod 2^16 wrap).
REQ-019 On pm_ack with discard = 1: data dropped; discard <= 0; fpc unchanged (already the redirect target).
REQ-020 Outputs SHALL come from the FIFO head only; no ack-to-output bypass, so a word is visible the cycle after its ack.
REQ-021 instr_valid = (count != 0); when 0, cur_instr = NOP_WORD and current_pc = fpc.
REQ-022 Pop SHALL occur when instr_valid = 1, stall = 0 and pc_src = 010.
REQ-023 Redirect SHALL occur for pc_src 000 (target 0) and 101 (target jmp) regardless of instr_valid/stall.
REQ-024 Redirect for pc_src 011 (target head.pc + 2) and 100 (target head.pc + jmp, 16-bit wrap) SHALL occur only when instr_valid = 1, regardless of stall.
REQ-025 On redirect: count <= 0, fpc <= target; if a request is outstanding and not acked this cycle, discard <= 1.
REQ-026 Redirect and pm_ack in the same cycle: acked word dropped, discard stays 0, new request to target next cycle.
REQ-027 Pop and push in the same cycle: count unchanged, FIFO order preserved; overflow is impossible by REQ-016.
REQ-028 Latency: redirect in cycle t, no outstanding request, zero-wait memory -> pm_req/pm_addr = target at t+1, instr_valid = 1 at t+2.
REQ-029 Hold (001, 11x) and stall = 1 SHALL not change the head; fetching continues until the FIFO is full.

Reset
REQ-030 While RST = 1: fpc = 0, count = 0, outstanding = 0, discard = 0, pm_req = 0, instr_valid = 0, cur_instr = NOP_WORD, current_pc = 0.
REQ-031 RST during an outstanding request SHALL abandon it; a pm_ack in the first cycle after RST deasserts with no request issued SHALL be ignored.
REQ-032 First request SHALL be pm_addr = 0 in the first cycle after RST deasserts.

Verification
REQ-033 Zero-wait memory returning pm_data = addr ^ 16'hA5A5, stall = 1 after reset -> pm_addr 0,1,2,3, then pm_req = 0 with count = 4; head = 16'hA5A5 at pc 0.
REQ-034 Streaming, stall = 0, pc_src = 010 -> current_pc 0,1,2,... one per cycle, no bubbles after the first valid word.
REQ-035 Request to 0x0005 outstanding (ack delayed 3 cycles), pc_src = 101 with jmp = 0x0100 -> 0x0005 data never visible; next pm_addr = 0x0100; first valid current_pc = 0x0100.
REQ-036 Head pc 0x0010, pc_src = 100, jmp = 0xFFFE -> next valid current_pc = 0x000E; head pc 0x0020, pc_src = 011 -> 0x0022; head 0xFFFF, pc_src = 010 -> fetch wraps to 0x0000.
REQ-037 FIFO full, pop and pm_ack in the same cycle -> count stays DEPTH, order intact; redirect with simultaneous ack -> no discard left set, request to target next cycle.
REQ-038 RST asserted mid-request, then released -> all outputs at REQ-030 values, first pm_addr = 0, stale pm_ack ignored.

Source files
------------

// File: rtl/avr_prefetch.sv
// Instruction prefetch queue for an AVR-style core.
// Fetches program words ahead of the CPU into a small FIFO of {pc, instr} pairs.
// Redirects flush the queue. A request already on the bus at redirect time is
// completed, and its returned word is dropped.

module avr_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic [2:0]  pc_src,
    input  logic [15:0] jmp,
    output logic        pm_req,
    output logic [15:0] pm_addr,
    input  logic        pm_ack,
    input  logic [15:0] pm_data,
    output logic [15:0] cur_instr,
    output logic [15:0] current_pc,
    output logic        instr_valid
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [15:0]   fpc_q, fpc_d;
    logic [15:0]   req_addr_q, req_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          outstanding_q, outstanding_d;
    logic          discard_q, discard_d;

    logic [15:0]   pc_mem    [DEPTH];
    logic [15:0]   instr_mem [DEPTH];

    logic [CW-1:0] fill;
    logic          head_valid, ack_v, push, pop, redirect;
    logic [15:0]   head_pc, head_instr, target;

    assign fill       = count_q + CW'(outstanding_q);
    assign head_valid = (count_q != '0);
    assign head_pc    = pc_mem[rd_ptr_q];
    assign head_instr = instr_mem[rd_ptr_q];

    // Bus request and CPU-facing outputs; all forced to idle values while in reset
    always_comb begin
        pm_req      = !RST && (outstanding_q || (fill < CW'(DEPTH)));
        // Address is latched once a request is on the bus so a redirect cannot move it
        pm_addr     = outstanding_q ? req_addr_q : fpc_q;
        instr_valid = !RST && head_valid;
        cur_instr   = instr_valid ? head_instr : NOP_WORD;
        current_pc  = instr_valid ? head_pc : (RST ? 16'h0000 : fpc_q);
    end

    // Decode PC control into redirect / pop decisions
    always_comb begin
        redirect = 1'b0;
        target   = fpc_q;
        case (pc_src)
            3'b000: begin
                redirect = 1'b1;
                target   = 16'h0000;
            end
            3'b011: begin
                redirect = head_valid;
                target   = head_pc + 16'd2;
            end
            3'b100: begin
                redirect = head_valid;
                target   = head_pc + jmp;
            end
            3'b101: begin
                redirect = 1'b1;
                target   = jmp;
            end
            default: ;
        endcase
        // An ack only counts against a live request, so stale acks fall through
        ack_v = pm_ack && pm_req;
        pop   = head_valid && !stall && (pc_src == 3'b010);
        push  = ack_v && !discard_q && !redirect;
    end

    // Next-state for fetch pointer, queue pointers and request tracking
    always_comb begin
        fpc_d         = fpc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        discard_d     = discard_q;
        outstanding_d = pm_req && !ack_v;
        req_addr_d    = (pm_req && !ack_v) ? pm_addr : req_addr_q;
        if (redirect) begin
            fpc_d     = target;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            // A request left on the bus now belongs to the old stream
            discard_d = pm_req && !ack_v;
        end else begin
            if (ack_v) begin
                discard_d = 1'b0;
            end
            if (push) begin
                fpc_d    = fpc_q + 16'd1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            fpc_q         <= 16'h0000;
            req_addr_q    <= 16'h0000;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            fpc_q         <= fpc_d;
            req_addr_q    <= req_addr_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Queue storage; contents are only observed when count is non-zero
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fpc_q;
            instr_mem[wr_ptr_q] <= pm_data;
        end
    end

endmodule

// File: tb/tb_avr_prefetch.sv
// Self-checking bench for avr_prefetch: directed scenarios plus a random phase,
// compared against a queue-based behavioural model of the prefetcher.

module tb_avr_prefetch;
    localparam int unsigned DEPTH    = 4;
    localparam logic [15:0] NOP_WORD = 16'hF00D;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall;
    logic [2:0]  pc_src;
    logic [15:0] jmp;
    logic        pm_req;
    logic [15:0] pm_addr;
    logic        pm_ack;
    logic [15:0] pm_data;
    logic [15:0] cur_instr;
    logic [15:0] current_pc;
    logic        instr_valid;

    avr_prefetch #(
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP_WORD)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .stall       (stall),
        .pc_src      (pc_src),
        .jmp         (jmp),
        .pm_req      (pm_req),
        .pm_addr     (pm_addr),
        .pm_ack      (pm_ack),
        .pm_data     (pm_data),
        .cur_instr   (cur_instr),
        .current_pc  (current_pc),
        .instr_valid (instr_valid)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [31:0] m_q[$];
    logic [15:0] m_fpc;
    logic [15:0] m_req_addr;
    bit          m_outst;
    bit          m_disc;

    // Memory responder state
    int          mem_cnt;
    int          mem_lat;
    int          min_lat;
    int          max_lat;
    bit          force_ack;
    logic [15:0] force_data;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick_lat();
        return int'($urandom_range(max_lat, min_lat));
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge
    task automatic cycle(input logic s, input logic [2:0] src, input logic [15:0] j);
        logic        req_e, valid_e, ackv, redir, pop;
        logic [15:0] addr_e, tgt;
        logic [31:0] head;
        stall  = s;
        pc_src = src;
        jmp    = j;
        req_e  = !RST && (m_outst || (m_q.size() < int'(DEPTH)));
        addr_e = m_outst ? m_req_addr : m_fpc;
        if (force_ack) begin
            pm_ack  = 1'b1;
            pm_data = force_data;
        end else if (req_e && (mem_cnt >= mem_lat)) begin
            pm_ack  = 1'b1;
            pm_data = addr_e ^ 16'hA5A5;
        end else begin
            pm_ack  = 1'b0;
            pm_data = 16'($urandom);
        end
        #4;
        head = 32'h0;
        if (m_q.size() != 0) head = m_q[0];
        valid_e = !RST && (m_q.size() != 0);
        check("pm_req", 16'(pm_req), 16'(req_e));
        if (req_e) check("pm_addr", pm_addr, addr_e);
        check("instr_valid", 16'(instr_valid), 16'(valid_e));
        check("cur_instr", cur_instr, valid_e ? head[15:0] : NOP_WORD);
        check("current_pc", current_pc, valid_e ? head[31:16] : (RST ? 16'h0000 : m_fpc));
        @(posedge CLK);
        ackv = pm_ack && req_e;
        if (RST) begin
            m_q.delete();
            m_fpc   = 16'h0000;
            m_outst = 1'b0;
            m_disc  = 1'b0;
            mem_cnt = 0;
            mem_lat = pick_lat();
        end else begin
            redir = 1'b0;
            tgt   = 16'h0000;
            case (src)
                3'b000: redir = 1'b1;
                3'b101: begin redir = 1'b1; tgt = j; end
                3'b011: begin redir = valid_e; tgt = head[31:16] + 16'd2; end
                3'b100: begin redir = valid_e; tgt = head[31:16] + j; end
                default: ;
            endcase
            pop = valid_e && !s && (src == 3'b010);
            if (req_e && !ackv) begin
                m_req_addr = addr_e;
                m_outst    = 1'b1;
            end else begin
                m_outst = 1'b0;
            end
            if (redir) begin
                m_q.delete();
                m_fpc  = tgt;
                m_disc = req_e && !ackv;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (ackv) begin
                    if (m_disc) begin
                        m_disc = 1'b0;
                    end else begin
                        m_q.push_back({m_fpc, pm_data});
                        m_fpc = m_fpc + 16'd1;
                    end
                end
            end
            if (ackv) begin
                mem_cnt = 0;
                mem_lat = pick_lat();
            end else if (req_e) begin
                mem_cnt++;
            end
        end
        #1;
    endtask

    // Hold until the model expects a valid head, bounded
    task automatic wait_valid();
        for (int i = 0; i < 16 && m_q.size() == 0; i++) cycle(1'b1, 3'b001, 16'h0000);
    endtask

    initial begin
        logic [2:0] src;
        int         r;
        bit         found;
        RST        = 1'b1;
        stall      = 1'b1;
        pc_src     = 3'b001;
        jmp        = 16'h0000;
        pm_ack     = 1'b0;
        pm_data    = 16'h0000;
        force_ack  = 1'b0;
        force_data = 16'h0000;
        m_fpc      = 16'h0000;
        m_req_addr = 16'h0000;
        m_outst    = 1'b0;
        m_disc     = 1'b0;
        min_lat    = 0;
        max_lat    = 0;
        mem_cnt    = 0;
        mem_lat    = 0;
        @(posedge CLK);
        #1;

        // Reset values
        cycle(1'b1, 3'b001, 16'h0000);
        cycle(1'b1, 3'b001, 16'h0000);
        check("rst_req", 16'(pm_req), 16'h0);
        check("rst_valid", 16'(instr_valid), 16'h0);
        check("rst_instr", cur_instr, NOP_WORD);
        check("rst_pc", current_pc, 16'h0000);
        RST = 1'b0;

        // Fill with stall: addresses 0..3 then stop requesting
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'b001, 16'h0000);
        check("fill_req", 16'(pm_req), 16'h0);
        check("fill_instr", cur_instr, 16'hA5A5);
        check("fill_pc", current_pc, 16'h0000);

        // Ack with no request is ignored
        force_ack  = 1'b1;
        force_data = 16'hDEAD;
        cycle(1'b1, 3'b001, 16'h0000);
        force_ack  = 1'b0;
        check("stale_req", 16'(pm_req), 16'h0);
        check("stale_pc", current_pc, 16'h0000);

        // Streaming: one instruction per cycle, no bubbles
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b0, 3'b010, 16'h0000);
            check("stream_pc", current_pc, 16'(i));
            check("stream_valid", 16'(instr_valid), 16'h1);
        end

        // Redirect while a request to 0x0005 is on the bus
        min_lat = 2;
        max_lat = 3;
        cycle(1'b1, 3'b101, 16'h0005);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle(1'b1, 3'b001, 16'h0000);
            found = m_outst && !m_disc && (m_req_addr == 16'h0005);
        end
        check("req5_seen", 16'(found), 16'h1);
        cycle(1'b1, 3'b101, 16'h0100);
        wait_valid();
        check("jmp_abs_pc", current_pc, 16'h0100);
        check("jmp_abs_instr", cur_instr, 16'h0100 ^ 16'hA5A5);

        // Relative, skip and wrap-around targets
        min_lat = 0;
        max_lat = 0;
        cycle(1'b1, 3'b101, 16'h0010);
        wait_valid();
        check("head_10", current_pc, 16'h0010);
        cycle(1'b1, 3'b100, 16'hFFFE);
        wait_valid();
        check("rel_pc", current_pc, 16'h000E);
        cycle(1'b1, 3'b101, 16'h0020);
        wait_valid();
        cycle(1'b1, 3'b011, 16'h0000);
        wait_valid();
        check("skip_pc", current_pc, 16'h0022);
        cycle(1'b1, 3'b101, 16'hFFFF);
        wait_valid();
        check("head_ffff", current_pc, 16'hFFFF);
        cycle(1'b0, 3'b010, 16'h0000);
        check("wrap_pc", current_pc, 16'h0000);
        check("wrap_instr", cur_instr, 16'hA5A5);

        // Redirect coinciding with an ack: word dropped, target fetched next cycle
        cycle(1'b1, 3'b101, 16'h0200);
        cycle(1'b1, 3'b001, 16'h0000);
        cycle(1'b1, 3'b101, 16'h0300);
        check("redir_ack_req", 16'(pm_req), 16'h1);
        check("redir_ack_addr", pm_addr, 16'h0300);
        cycle(1'b1, 3'b001, 16'h0000);
        check("redir_ack_valid", 16'(instr_valid), 16'h1);
        check("redir_ack_pc", current_pc, 16'h0300);

        // Reset in the middle of a request, with a stale ack during reset
        mem_lat = 3;
        mem_cnt = 0;
        cycle(1'b1, 3'b101, 16'h0050);
        cycle(1'b1, 3'b001, 16'h0000);
        RST        = 1'b1;
        force_ack  = 1'b1;
        force_data = 16'hBEEF;
        cycle(1'b1, 3'b001, 16'h0000);
        check("midrst_req", 16'(pm_req), 16'h0);
        check("midrst_instr", cur_instr, NOP_WORD);
        cycle(1'b1, 3'b001, 16'h0000);
        force_ack = 1'b0;
        RST       = 1'b0;
        mem_lat   = 1;
        cycle(1'b1, 3'b001, 16'h0000);
        check("post_rst_addr", pm_addr, 16'h0000);
        wait_valid();
        check("post_rst_pc", current_pc, 16'h0000);
        check("post_rst_instr", cur_instr, 16'hA5A5);

        // Random traffic with variable memory latency
        min_lat = 0;
        max_lat = 3;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(99, 0));
            if (r < 50)      src = 3'b010;
            else if (r < 66) src = 3'b001;
            else if (r < 74) src = 3'($urandom_range(7, 6));
            else if (r < 84) src = 3'b100;
            else if (r < 92) src = 3'b011;
            else if (r < 97) src = 3'b101;
            else             src = 3'b000;
            cycle(($urandom_range(3, 0) == 0), src, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
